fifo_read_stream: RTL and testbench

Read-side consumer for the FIFO read port: drives the FIFO read enable, absorbs the one-cycle registered read latency of the FIFO memory, and presents words downstream as a first-word-fall-through valid/ready stream. Sits in the read clock domain, between the read-side signal generator and memory, and any pipeline stage that consumes FIFO data. A 2-entry output buffer sustains one word per cycle while `i_ready` is held high. It never loses or duplicates words under backpressure.

---
 rtl/fifo_read_stream.sv | 67 ++++++
 tb/tb_fifo_read_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: FIFO read-port consumer.
// Absorbs the one-cycle registered read latency of the FIFO memory and
// presents words as a first-word-fall-through valid/ready stream, using a
// 2-entry skid buffer so one word per cycle is sustained under i_ready=1.
module fifo_read_stream #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_empty,
    output logic             o_rd_en,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q;
    logic             pop, push;
    logic [1:0]       occ;

    // Handshake, issue rule and next-state pointers/count.
    // A read may be issued only if its word is guaranteed a buffer slot:
    // buffered + in-flight words stay at or below 2 after the edge.
    always_comb begin
        pop     = (count_q != 2'd0) & i_ready;
        push    = inflight_q;
        occ     = count_q + {1'b0, inflight_q};
        o_rd_en = ~i_rst & ~i_empty & ((occ < 2'd2) | pop);
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Buffer state; reset also drops any word still returning from the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (push) mem_q[tail_q] <= i_rd_data;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= o_rd_en;
        end
    end

    // Outputs come straight from registers, never gated by i_ready.
    assign o_valid = (count_q != 2'd0);
    assign o_data  = mem_q[head_q];
    assign o_count = count_q;

    // The issue rule makes an overflowing push impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a table of directed vectors, hand-written
// streaming/backpressure/reset sequences, and a randomized run scored
// against an in-order queue model of the FIFO contents.
module tb_fifo_read_stream;

    localparam int WIDTH = 32;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_empty;
    logic             o_rd_en;
    logic [WIDTH-1:0] i_rd_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_count;

    fifo_read_stream #(.WIDTH(WIDTH)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_empty   (i_empty),
        .o_rd_en   (o_rd_en),
        .i_rd_data (i_rd_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_count   (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic             rst;
        logic             hold_empty;
        logic             ready;
        logic             exp_rd_en;
        logic             exp_valid;
        logic [1:0]       exp_count;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    logic [WIDTH-1:0] fifo_q[$];   // words held in the FIFO memory
    logic [WIDTH-1:0] ref_q[$];    // words expected downstream, in order
    logic             rd_last;     // o_rd_en seen in the previous cycle
    int               n_pass = 0;
    int               n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: the FIFO memory returns the word read last cycle (garbage
    // otherwise), new inputs are applied, outputs settle for sampling.
    task automatic drive(input logic rst, input logic hold_empty, input logic ready);
        @(negedge i_clk);
        if (rd_last && fifo_q.size() > 0) i_rd_data = fifo_q.pop_front();
        else i_rd_data = $urandom;
        i_rst   = rst;
        i_ready = ready;
        i_empty = hold_empty | (fifo_q.size() == 0);
        #1;
        rd_last = o_rd_en;
    endtask

    initial begin
        vec_t tbl[6];
        int   pulses;
        int   issued, accepted, pushed, out_before, exp_cnt;
        logic prev_rd, hold_prev;
        logic [WIDTH-1:0] hold_data, exp_w;

        i_rst = 1'b1; i_empty = 1'b1; i_ready = 1'b0; i_rd_data = '0; rd_last = 1'b0;

        // reset, release, and a single word through the pipeline
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
        fifo_q.push_back(32'hA5A5_0001);
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].rst, tbl[i].hold_empty, tbl[i].ready);
            check($sformatf("vec%0d rd_en", i), o_rd_en, tbl[i].exp_rd_en);
            check($sformatf("vec%0d valid", i), o_valid, tbl[i].exp_valid);
            check($sformatf("vec%0d count", i), o_count, tbl[i].exp_count);
            check($sformatf("vec%0d data", i), o_data, tbl[i].exp_data);
        end

        // streaming: 8 reads back to back, words out two cycles later
        for (int k = 0; k < 8; k++) fifo_q.push_back(32'h100 + k);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            check($sformatf("stream c%0d rd_en", c), o_rd_en, (c < 8));
            check($sformatf("stream c%0d valid", c), o_valid, (c >= 2 && c < 10));
            if (c >= 2 && c < 10) check($sformatf("stream c%0d data", c), o_data, 32'h100 + c - 2);
        end

        // backpressure: two reads, buffer full, head word stable
        for (int k = 0; k < 8; k++) fifo_q.push_back(32'h200 + k);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            pulses += int'(o_rd_en);
            if (c >= 2) begin
                check($sformatf("bp c%0d valid", c), o_valid, 1'b1);
                check($sformatf("bp c%0d data", c), o_data, 32'h200);
            end
        end
        check("bp rd_en pulses", pulses, 2);
        check("bp count", o_count, 2'd2);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (k == 0) check("bp release rd_en", o_rd_en, 1'b1);
            check($sformatf("bp drain%0d valid", k), o_valid, 1'b1);
            check($sformatf("bp drain%0d data", k), o_data, 32'h200 + k);
        end
        drive(1'b0, 1'b0, 1'b1);
        check("bp drained valid", o_valid, 1'b0);

        // reset the cycle after a read: returning word must be dropped
        for (int k = 0; k < 4; k++) fifo_q.push_back(32'h300 + k);
        drive(1'b0, 1'b0, 1'b0);
        check("midrst issue", o_rd_en, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        check("midrst rd_en in reset", o_rd_en, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check("midrst valid", o_valid, 1'b0);
        check("midrst count", o_count, 2'd0);
        drive(1'b0, 1'b1, 1'b0);
        check("midrst no push", o_count, 2'd0);
        fifo_q.delete();

        // random ready / empty gaps over 1000 words
        issued = 0; accepted = 0; pushed = 0;
        prev_rd = 1'b0; hold_prev = 1'b0; hold_data = '0;
        for (int cyc = 0; cyc < 30000 && accepted < 1000; cyc++) begin
            if (pushed < 1000 && fifo_q.size() < 6 && $urandom_range(0, 3) != 0) begin
                exp_w = $urandom;
                fifo_q.push_back(exp_w);
                ref_q.push_back(exp_w);
                pushed++;
            end
            drive(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
            out_before = issued - accepted;
            exp_cnt = out_before - int'(prev_rd);
            check("rnd occupancy<=2", (out_before <= 2), 1'b1);
            check("rnd count", o_count, exp_cnt);
            if (o_rd_en) check("rnd rd_en while empty", i_empty, 1'b0);
            if (!i_empty && exp_cnt == 0 && !prev_rd) check("rnd idle fetch", o_rd_en, 1'b1);
            if (hold_prev) begin
                check("rnd hold valid", o_valid, 1'b1);
                check("rnd hold data", o_data, hold_data);
            end
            if (o_valid && i_ready) begin
                if (ref_q.size() == 0) check("rnd extra word", 1'b1, 1'b0);
                else check("rnd order", o_data, ref_q.pop_front());
                accepted++;
            end
            hold_prev = o_valid & ~i_ready;
            hold_data = o_data;
            issued += int'(o_rd_en);
            prev_rd = o_rd_en;
        end
        check("rnd delivered", accepted, 1000);
        check("rnd issued", issued, 1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
